prefetcher_block_queue: RTL and testbench
=========================================

# prefetcher_block_queue

Circular queue of prefetched cache blocks sitting between the prefetcher control FSM and the AXI read channels. Allocates an entry per issued read request (AR), assembles multi-beat read data (R) into the oldest outstanding entry, and answers registered address lookups with HIT, PENDING or MISS. Consumed and older blocks are retired, and stale filled blocks are evicted by a watchdog.

## Interface
- LOG_QUEUE_SIZE, 4, log2 of entry count.
- ADDR_WIDTH, 64, block-aligned address width in bits.
- BEAT_WIDTH, 64, R data beat width in bits.
- LOG_BEATS, 3, log2 of beats per block; BLOCK_WIDTH = BEAT_WIDTH << LOG_BEATS.
- WATCHDOG_SIZE, 10, watchdog prescaler width.
- clk in 1: the single clock.
- resetN in 1: asynchronous, active-high reset (asserted = 1).
- allocValid in 1, allocAddr in ADDR_WIDTH, allocReady out 1: AR-side allocate handshake.
- respValid in 1, respData in BEAT_WIDTH, respLast in 1, respReady out 1: R-side beat handshake.
- lookupValid in 1, lookupAddr in ADDR_WIDTH, lookupReady out 1: lookup request.
- hitValid out 1, hitStatus out 2 (0 MISS, 1 PENDING, 2 HIT), hitData out BLOCK_WIDTH: lookup result.
- flush in 1: retire all filled entries.
- watchdogCnt in WATCHDOG_SIZE: watchdog tick period in cycles, minus 1.
- almostFullSpacer in LOG_QUEUE_SIZE+1: almostFull threshold distance.
- occupancy out LOG_QUEUE_SIZE+1, outstandingCnt out LOG_QUEUE_SIZE+1.
- empty, full, almostFull out 1.
- protoErr out 1: sticky error.

## Operation
- Entry state is one of FREE, OUTSTANDING or FILLED; each entry also holds an age bit, a valid bit, an address and data. Pointers are headPtr, fillPtr and tailPtr, each LOG_QUEUE_SIZE+1 bits with a wrap bit. occupancy = tail−head; outstandingCnt = tail−fill. All arithmetic is modulo 2^(LOG_QUEUE_SIZE+1).
- full = (occupancy == 2^LOG_QUEUE_SIZE); empty = (occupancy == 0); almostFull = (occupancy + almostFullSpacer ≥ 2^LOG_QUEUE_SIZE), evaluated at LOG_QUEUE_SIZE+2 bits so it cannot overflow.
- Alloc: allocReady = !full. On allocValid&&allocReady the entry at tail becomes OUTSTANDING with the address stored and age=0, and tail increments.
- Resp: respReady = (outstandingCnt != 0). A beat counter of LOG_BEATS bits writes beat k into bits [k*BEAT_WIDTH +: BEAT_WIDTH], where beat 0 is the LSBs. On the accepted beat with counter == BEATS−1, the entry at fill becomes FILLED with age=0, fill increments and the counter clears.
- protoErr is set if respLast differs from (counter == BEATS−1) on an accepted beat. Data is still taken per the counter.
- Lookup: lookupReady = !flush. Only non-FREE, valid entries in [head, tail) are compared; the oldest match wins. The result is registered.
  - FILLED match: status HIT, data = entry data, head ← idx+1.
  - OUTSTANDING match: status PENDING, head ← idx; older entries are discarded.
  - No match: status MISS, no state change; the top level decides whether to flush.
- Flush: head ← fill, so all FILLED entries are freed. OUTSTANDING entries are kept so that in-flight beats still land. Flush has priority over lookup-retire and scrub.
- Scrub: when no lookup or flush is retiring and the head entry is FILLED but invalid (evicted), head increments by one. This is at most one entry per cycle.
- Watchdog (macro-gated): a prescaler counts 0..watchdogCnt and pulses a tick on wrap. On tick, FILLED entries with age=1 get valid=0, and all FILLED entries get age ← 1. Alloc and fill force age=0 on their entry in the same cycle. OUTSTANDING entries never age.

## Timing
- Reset (async, resetN=1) values:
  - All pointers = 0 and all entries FREE.
  - hitValid = 0, hitStatus = 0, hitData = 0.
  - protoErr = 0, prescaler = 0.
  - empty = 1, full = 0, almostFull = (almostFullSpacer ≥ 2^LOG_QUEUE_SIZE).
  - allocReady = 1, respReady = 0.
- A reset mid-burst discards partial beats.
- Lookup latency: sampled at edge N, hitValid/hitStatus/hitData valid for exactly the cycle after N. The pointer update commits at edge N.
- A lookup evaluates pre-edge state. A final beat arriving in the same cycle as a lookup of that entry reports PENDING. A lookup of an address being allocated in the same cycle reports MISS.
- Alloc, fill and retire in the same cycle are all applied. allocReady depends only on registered state, so there is no combinational path from lookup.
- When full, alloc stalls. Pointer wrap is handled by the wrap bit.

## Configuration
- PREFETCH_WATCHDOG_EN defined: the prescaler, age bits and eviction are present.
- PREFETCH_WATCHDOG_EN undefined: no prescaler and no age bits are synthesised, watchdogCnt is ignored, and FILLED entries stay valid until retired or flushed.

## Structure
- Package prefetcher_pkg holds hitStatus_t (MISS/PENDING/HIT) and entryState_t (FREE/OUTSTANDING/FILLED).
- One sub-module, pf_age_watchdog, holds the prescaler, the tick and the per-entry age/evict vector generation.

## Test plan
Bench configuration for all scenarios: LOG_QUEUE_SIZE=2, LOG_BEATS=1, BEAT_WIDTH=8, watchdogCnt=3.

- Alloc 0x40, 0x80 → beats 0x11 then 0x22 with last on the 2nd → lookup 0x40 → next cycle HIT, data 0x2211, occupancy=1, outstandingCnt=1.
- Alloc 4 entries → full=1, allocReady=0, with almostFullSpacer=1 → almostFull=1 at occupancy 3. Then 2 HIT retires and 2 allocs cross the wrap → occupancy correct and full=1 again.
- Lookup of the 3rd of 3 outstanding entries → PENDING, head=2, outstandingCnt=3, and subsequent beats still fill entries 0 and 1 (discarded, fill advances).
- Beat with respLast=1 on beat 0 → protoErr=1, sticky across later good bursts until reset.
- Fill 0x40 and idle 8+ cycles with the macro defined → lookup 0x40 gives MISS and the head scrubs to tail. With the macro undefined → HIT.
- Two filled entries plus one outstanding, flush with a simultaneous lookup → lookupReady=0, occupancy=1, the outstanding entry fills afterwards and a lookup of it gives HIT.

Source files
------------

// File: rtl/prefetcher_pkg.sv
// prefetcher_pkg: shared types for the prefetcher block queue.
package prefetcher_pkg;

   // Lookup result encoding, as presented on hitStatus.
   typedef enum logic [1:0] {
      HIT_MISS    = 2'd0,
      HIT_PENDING = 2'd1,
      HIT_HIT     = 2'd2
   } hitStatus_t;

   // Lifecycle of one queue entry.
   typedef enum logic [1:0] {
      ENTRY_FREE        = 2'd0,
      ENTRY_OUTSTANDING = 2'd1,
      ENTRY_FILLED      = 2'd2
   } entryState_t;

endpackage

// File: rtl/pf_age_watchdog.sv
// pf_age_watchdog: prescaled tick plus per-entry age bits.
// A FILLED entry is evicted on the second tick it sees without being touched.
// Only instantiated when PREFETCH_WATCHDOG_EN is defined.
module pf_age_watchdog #(
   parameter int unsigned NUM_ENTRIES   = 16,
   parameter int unsigned WATCHDOG_SIZE = 10
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [WATCHDOG_SIZE-1:0] i_period,
   input  logic [NUM_ENTRIES-1:0]   i_filled,
   input  logic [NUM_ENTRIES-1:0]   i_clrAge,
   output logic [NUM_ENTRIES-1:0]   o_evict
);

   logic [WATCHDOG_SIZE-1:0] r_presc;
   logic [NUM_ENTRIES-1:0]   r_age;
   logic                     w_tick;

   assign w_tick  = (r_presc == i_period);
   assign o_evict = {NUM_ENTRIES{w_tick}} & i_filled & r_age;

   // Prescaler counts 0..i_period and ticks on wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + WATCHDOG_SIZE'(1);
      end
   end

   // Tick marks every filled entry as aged; alloc/fill clearing wins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_age <= '0;
      end else begin
         r_age <= (w_tick ? (r_age | i_filled) : r_age) & ~i_clrAge;
      end
   end

endmodule

// File: rtl/prefetcher_block_queue.sv
// prefetcher_block_queue: circular queue of prefetched cache blocks between
// the prefetcher control FSM and the AXI AR/R channels. Allocates on AR,
// assembles R beats into the oldest outstanding entry, answers registered
// lookups with HIT/PENDING/MISS, retires consumed blocks.
// Optional feature: define PREFETCH_WATCHDOG_EN for age-based eviction.
module prefetcher_block_queue
   import prefetcher_pkg::*;
#(
   parameter int unsigned LOG_QUEUE_SIZE = 4,
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned BEAT_WIDTH     = 64,
   parameter int unsigned LOG_BEATS      = 3,
   parameter int unsigned WATCHDOG_SIZE  = 10
) (
   input  logic                                clk,
   input  logic                                resetN,
   input  logic                                allocValid,
   input  logic [ADDR_WIDTH-1:0]               allocAddr,
   output logic                                allocReady,
   input  logic                                respValid,
   input  logic [BEAT_WIDTH-1:0]               respData,
   input  logic                                respLast,
   output logic                                respReady,
   input  logic                                lookupValid,
   input  logic [ADDR_WIDTH-1:0]               lookupAddr,
   output logic                                lookupReady,
   output logic                                hitValid,
   output logic [1:0]                          hitStatus,
   output logic [(BEAT_WIDTH<<LOG_BEATS)-1:0]  hitData,
   input  logic                                flush,
   input  logic [WATCHDOG_SIZE-1:0]            watchdogCnt,
   input  logic [LOG_QUEUE_SIZE:0]             almostFullSpacer,
   output logic [LOG_QUEUE_SIZE:0]             occupancy,
   output logic [LOG_QUEUE_SIZE:0]             outstandingCnt,
   output logic                                empty,
   output logic                                full,
   output logic                                almostFull,
   output logic                                protoErr
);

   localparam int unsigned QS          = 1 << LOG_QUEUE_SIZE;
   localparam int unsigned PW          = LOG_QUEUE_SIZE + 1;
   localparam int unsigned BLOCK_WIDTH = BEAT_WIDTH << LOG_BEATS;
   localparam logic [PW-1:0] QS_P      = QS[PW-1:0];
   localparam logic [PW:0]   QS_X      = QS[PW:0];

   entryState_t                 r_state [QS];
   logic [QS-1:0]               r_valid;
   logic [ADDR_WIDTH-1:0]       r_addr  [QS];
   logic [BLOCK_WIDTH-1:0]      r_data  [QS];
   logic [PW-1:0]               r_head, r_fill, r_tail;
   logic [LOG_BEATS-1:0]        r_beatCnt;
   logic                        r_hitValid;
   hitStatus_t                  r_hitStatus;
   logic [BLOCK_WIDTH-1:0]      r_hitData;
   logic                        r_protoErr;

   logic [PW-1:0]               w_occ, w_outst, w_headNext, w_retCnt, w_foundOff;
   logic [LOG_QUEUE_SIZE-1:0]   w_headIdx, w_fillIdx, w_tailIdx, w_scanIdx, w_foundIdx;
   logic                        w_allocFire, w_respFire, w_fillDone, w_lookupFire;
   logic                        w_found, w_foundFilled;
   hitStatus_t                  w_status;
   logic [BLOCK_WIDTH-1:0]      w_hitData;
   logic [QS-1:0]               w_evict;

   assign w_headIdx  = r_head[LOG_QUEUE_SIZE-1:0];
   assign w_fillIdx  = r_fill[LOG_QUEUE_SIZE-1:0];
   assign w_tailIdx  = r_tail[LOG_QUEUE_SIZE-1:0];

   assign w_occ          = r_tail - r_head;
   assign w_outst        = r_tail - r_fill;
   assign occupancy      = w_occ;
   assign outstandingCnt = w_outst;
   assign full           = (w_occ == QS_P);
   assign empty          = (w_occ == '0);
   assign almostFull     = (({1'b0, w_occ} + {1'b0, almostFullSpacer}) >= QS_X);

   assign allocReady   = !full;
   assign respReady    = (w_outst != '0);
   assign lookupReady  = !flush;
   assign w_allocFire  = allocValid && !full;
   assign w_respFire   = respValid && (w_outst != '0);
   assign w_fillDone   = w_respFire && (&r_beatCnt);
   assign w_lookupFire = lookupValid && !flush;

   assign hitValid  = r_hitValid;
   assign hitStatus = r_hitStatus;
   assign hitData   = r_hitData;
   assign protoErr  = r_protoErr;

   // Oldest live entry in [head, tail) matching the lookup address.
   always_comb begin
      w_found    = 1'b0;
      w_foundOff = '0;
      w_foundIdx = '0;
      w_scanIdx  = '0;
      for (int unsigned k = 0; k < QS; k++) begin
         w_scanIdx = w_headIdx + LOG_QUEUE_SIZE'(k);
         if (!w_found && (PW'(k) < w_occ) && (r_state[w_scanIdx] != ENTRY_FREE) &&
             r_valid[w_scanIdx] && (r_addr[w_scanIdx] == lookupAddr)) begin
            w_found    = 1'b1;
            w_foundOff = PW'(k);
            w_foundIdx = w_scanIdx;
         end
      end
   end

   assign w_foundFilled = (r_state[w_foundIdx] == ENTRY_FILLED);

   // Lookup result to be registered; non-HIT results carry zero data.
   always_comb begin
      w_status  = HIT_MISS;
      w_hitData = '0;
      if (w_lookupFire && w_found) begin
         if (w_foundFilled) begin
            w_status  = HIT_HIT;
            w_hitData = r_data[w_foundIdx];
         end else begin
            w_status  = HIT_PENDING;
         end
      end
   end

   // Head advance: flush beats lookup retire, which beats single-entry scrub.
   always_comb begin
      w_headNext = r_head;
      if (flush) begin
         w_headNext = r_fill;
      end else if (w_lookupFire && w_found) begin
         w_headNext = r_head + w_foundOff + PW'(w_foundFilled);
      end else if ((w_occ != '0) && (r_state[w_headIdx] == ENTRY_FILLED) && !r_valid[w_headIdx]) begin
         w_headNext = r_head + PW'(1);
      end
   end

   assign w_retCnt = w_headNext - r_head;

   // Pointers, beat counter, entry state/valid, protocol flag and lookup result.
   // Retired entries are freed except OUTSTANDING ones, which must still
   // absorb their in-flight beats; alloc/fill writes come last and win.
   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         r_head      <= '0;
         r_fill      <= '0;
         r_tail      <= '0;
         r_beatCnt   <= '0;
         r_hitValid  <= 1'b0;
         r_hitStatus <= HIT_MISS;
         r_hitData   <= '0;
         r_protoErr  <= 1'b0;
         r_valid     <= '0;
         for (int unsigned i = 0; i < QS; i++) begin
            r_state[i] <= ENTRY_FREE;
         end
      end else begin
         r_head      <= w_headNext;
         r_hitValid  <= w_lookupFire;
         r_hitStatus <= w_status;
         r_hitData   <= w_hitData;
         if (w_allocFire) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_fillDone) begin
            r_fill <= r_fill + PW'(1);
         end
         if (w_respFire) begin
            r_beatCnt <= r_beatCnt + LOG_BEATS'(1);
            if (respLast != (&r_beatCnt)) begin
               r_protoErr <= 1'b1;
            end
         end
         for (int unsigned i = 0; i < QS; i++) begin
            if (({1'b0, LOG_QUEUE_SIZE'(i) - w_headIdx} < w_retCnt) &&
                (r_state[i] != ENTRY_OUTSTANDING)) begin
               r_state[i] <= ENTRY_FREE;
            end
            if (w_evict[i]) begin
               r_valid[i] <= 1'b0;
            end
         end
         if (w_allocFire) begin
            r_state[w_tailIdx] <= ENTRY_OUTSTANDING;
            r_valid[w_tailIdx] <= 1'b1;
         end
         if (w_fillDone) begin
            r_state[w_fillIdx] <= ENTRY_FILLED;
            r_valid[w_fillIdx] <= 1'b1;
         end
      end
   end

   // Address capture on alloc and beat assembly into the fill entry.
   always_ff @(posedge clk) begin
      if (w_allocFire) begin
         r_addr[w_tailIdx] <= allocAddr;
      end
      if (w_respFire) begin
         r_data[w_fillIdx][r_beatCnt*BEAT_WIDTH +: BEAT_WIDTH] <= respData;
      end
   end

`ifdef PREFETCH_WATCHDOG_EN
   logic [QS-1:0] w_filled, w_clrAge;

   // Filled-entry vector and age-clear strobes for this cycle's alloc/fill.
   always_comb begin
      w_filled = '0;
      w_clrAge = '0;
      for (int unsigned i = 0; i < QS; i++) begin
         w_filled[i] = (r_state[i] == ENTRY_FILLED);
      end
      if (w_allocFire) begin
         w_clrAge[w_tailIdx] = 1'b1;
      end
      if (w_fillDone) begin
         w_clrAge[w_fillIdx] = 1'b1;
      end
   end

   pf_age_watchdog #(
      .NUM_ENTRIES   (QS),
      .WATCHDOG_SIZE (WATCHDOG_SIZE)
   ) u_watchdog (
      .i_clk    (clk),
      .i_rst    (resetN),
      .i_period (watchdogCnt),
      .i_filled (w_filled),
      .i_clrAge (w_clrAge),
      .o_evict  (w_evict)
   );
`else
   logic w_unused_wdog;
   assign w_unused_wdog = ^watchdogCnt;
   assign w_evict       = '0;
`endif

endmodule

// File: tb/tb_prefetcher_block_queue.sv
// tb_prefetcher_block_queue: directed, table-driven checks of the block queue
// with 4 entries, 2 beats of 8 bits per block and a watchdog period of 4.
module tb_prefetcher_block_queue;

   localparam int unsigned LQ = 2;
   localparam int unsigned AW = 64;
   localparam int unsigned BW = 8;
   localparam int unsigned LB = 1;
   localparam int unsigned WS = 10;
   localparam int unsigned NV = 19;

   logic           clk = 1'b0;
   logic           resetN = 1'b1;
   logic           allocValid = 1'b0;
   logic [AW-1:0]  allocAddr = '0;
   logic           allocReady;
   logic           respValid = 1'b0;
   logic [BW-1:0]  respData = '0;
   logic           respLast = 1'b0;
   logic           respReady;
   logic           lookupValid = 1'b0;
   logic [AW-1:0]  lookupAddr = '0;
   logic           lookupReady;
   logic           hitValid;
   logic [1:0]     hitStatus;
   logic [15:0]    hitData;
   logic           flush = 1'b0;
   logic [WS-1:0]  watchdogCnt = 10'd3;
   logic [LQ:0]    almostFullSpacer = 3'd1;
   logic [LQ:0]    occupancy, outstandingCnt;
   logic           empty, full, almostFull, protoErr;

   int unsigned total = 0;
   int unsigned bad   = 0;

   typedef struct {
      logic        aV;
      logic [63:0] aA;
      logic        rV;
      logic [7:0]  rD;
      logic        rL;
      logic        lV;
      logic [63:0] lA;
      int unsigned occ;
      int unsigned outst;
      logic        full;
      logic        af;
      logic        hv;
      logic [1:0]  hs;
      logic [15:0] hd;
   } vec_t;

   vec_t v [NV];

   prefetcher_block_queue #(
      .LOG_QUEUE_SIZE (LQ),
      .ADDR_WIDTH     (AW),
      .BEAT_WIDTH     (BW),
      .LOG_BEATS      (LB),
      .WATCHDOG_SIZE  (WS)
   ) dut (
      .clk              (clk),
      .resetN           (resetN),
      .allocValid       (allocValid),
      .allocAddr        (allocAddr),
      .allocReady       (allocReady),
      .respValid        (respValid),
      .respData         (respData),
      .respLast         (respLast),
      .respReady        (respReady),
      .lookupValid      (lookupValid),
      .lookupAddr       (lookupAddr),
      .lookupReady      (lookupReady),
      .hitValid         (hitValid),
      .hitStatus        (hitStatus),
      .hitData          (hitData),
      .flush            (flush),
      .watchdogCnt      (watchdogCnt),
      .almostFullSpacer (almostFullSpacer),
      .occupancy        (occupancy),
      .outstandingCnt   (outstandingCnt),
      .empty            (empty),
      .full             (full),
      .almostFull       (almostFull),
      .protoErr         (protoErr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic aV, input logic [63:0] aA, input logic rV,
                               input logic [7:0] rD, input logic rL, input logic lV,
                               input logic [63:0] lA, input int unsigned occ,
                               input int unsigned outst, input logic fu, input logic af,
                               input logic hv, input logic [1:0] hs, input logic [15:0] hd);
      vec_t r;
      r.aV = aV; r.aA = aA; r.rV = rV; r.rD = rD; r.rL = rL; r.lV = lV; r.lA = lA;
      r.occ = occ; r.outst = outst; r.full = fu; r.af = af; r.hv = hv; r.hs = hs; r.hd = hd;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      allocValid  = 1'b0;
      respValid   = 1'b0;
      respLast    = 1'b0;
      lookupValid = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetN = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      resetN = 1'b0;
   endtask

   task automatic do_alloc(input logic [63:0] a);
      allocValid = 1'b1;
      allocAddr  = a;
      cyc();
      allocValid = 1'b0;
   endtask

   task automatic do_beat(input logic [7:0] d, input logic l);
      respValid = 1'b1;
      respData  = d;
      respLast  = l;
      cyc();
      respValid = 1'b0;
      respLast  = 1'b0;
   endtask

   task automatic do_lookup(input logic [63:0] a);
      lookupValid = 1'b1;
      lookupAddr  = a;
      cyc();
      lookupValid = 1'b0;
   endtask

   task automatic chk_q(input string nm, input int unsigned occ, input int unsigned outst);
      chk({nm, ".occ"}, 64'(occupancy), 64'(occ));
      chk({nm, ".outst"}, 64'(outstandingCnt), 64'(outst));
   endtask

   task automatic chk_hit(input string nm, input logic hv, input logic [1:0] hs, input logic [15:0] hd);
      chk({nm, ".hv"}, 64'(hitValid), 64'(hv));
      chk({nm, ".hs"}, 64'(hitStatus), 64'(hs));
      chk({nm, ".hd"}, 64'(hitData), 64'(hd));
   endtask

   initial begin
      // aV aA     rV rD    rL lV lA      occ out full af  hv hs  hd
      v[0]  = mk(1, 64'h40,  0, 8'h00, 0, 0, 64'h0,   1, 1, 0, 0, 0, 2'd0, 16'h0);
      v[1]  = mk(1, 64'h80,  0, 8'h00, 0, 0, 64'h0,   2, 2, 0, 0, 0, 2'd0, 16'h0);
      v[2]  = mk(0, 64'h0,   1, 8'h11, 0, 0, 64'h0,   2, 2, 0, 0, 0, 2'd0, 16'h0);
      v[3]  = mk(0, 64'h0,   1, 8'h22, 1, 0, 64'h0,   2, 1, 0, 0, 0, 2'd0, 16'h0);
      v[4]  = mk(0, 64'h0,   0, 8'h00, 0, 1, 64'h40,  1, 1, 0, 0, 1, 2'd2, 16'h2211);
      v[5]  = mk(0, 64'h0,   0, 8'h00, 0, 0, 64'h0,   1, 1, 0, 0, 0, 2'd0, 16'h0);
      v[6]  = mk(1, 64'hC0,  0, 8'h00, 0, 0, 64'h0,   2, 2, 0, 0, 0, 2'd0, 16'h0);
      v[7]  = mk(1, 64'h100, 0, 8'h00, 0, 0, 64'h0,   3, 3, 0, 1, 0, 2'd0, 16'h0);
      v[8]  = mk(1, 64'h140, 0, 8'h00, 0, 0, 64'h0,   4, 4, 1, 1, 0, 2'd0, 16'h0);
      v[9]  = mk(1, 64'h180, 0, 8'h00, 0, 0, 64'h0,   4, 4, 1, 1, 0, 2'd0, 16'h0);
      v[10] = mk(0, 64'h0,   1, 8'hA1, 0, 0, 64'h0,   4, 4, 1, 1, 0, 2'd0, 16'h0);
      v[11] = mk(0, 64'h0,   1, 8'hB2, 1, 0, 64'h0,   4, 3, 1, 1, 0, 2'd0, 16'h0);
      v[12] = mk(0, 64'h0,   1, 8'hC3, 0, 0, 64'h0,   4, 3, 1, 1, 0, 2'd0, 16'h0);
      v[13] = mk(0, 64'h0,   1, 8'hD4, 1, 0, 64'h0,   4, 2, 1, 1, 0, 2'd0, 16'h0);
      v[14] = mk(0, 64'h0,   0, 8'h00, 0, 1, 64'h80,  3, 2, 0, 1, 1, 2'd2, 16'hB2A1);
      v[15] = mk(0, 64'h0,   0, 8'h00, 0, 1, 64'hC0,  2, 2, 0, 0, 1, 2'd2, 16'hD4C3);
      v[16] = mk(1, 64'h180, 0, 8'h00, 0, 0, 64'h0,   3, 3, 0, 1, 0, 2'd0, 16'h0);
      v[17] = mk(1, 64'h1C0, 0, 8'h00, 0, 0, 64'h0,   4, 4, 1, 1, 0, 2'd0, 16'h0);
      v[18] = mk(0, 64'h0,   0, 8'h00, 0, 1, 64'h100, 4, 4, 1, 1, 1, 2'd1, 16'h0);

      // reset values, including the almostFull boundary on the spacer alone
      #2;
      chk("rst.empty", 64'(empty), 64'd1);
      chk("rst.full", 64'(full), 64'd0);
      chk("rst.allocReady", 64'(allocReady), 64'd1);
      chk("rst.respReady", 64'(respReady), 64'd0);
      chk("rst.protoErr", 64'(protoErr), 64'd0);
      chk_q("rst", 0, 0);
      chk_hit("rst", 1'b0, 2'd0, 16'h0);
      chk("rst.af_sp1", 64'(almostFull), 64'd0);
      almostFullSpacer = 3'd4;
      #1;
      chk("rst.af_sp4", 64'(almostFull), 64'd1);
      almostFullSpacer = 3'd3;
      #1;
      chk("rst.af_sp3", 64'(almostFull), 64'd0);
      almostFullSpacer = 3'd1;
      @(posedge clk);
      #1;
      resetN = 1'b0;

      // table: fill/HIT, fill to full, stall, retire, wrap, PENDING at head
      for (int i = 0; i < int'(NV); i++) begin
         allocValid  = v[i].aV;
         allocAddr   = v[i].aA;
         respValid   = v[i].rV;
         respData    = v[i].rD;
         respLast    = v[i].rL;
         lookupValid = v[i].lV;
         lookupAddr  = v[i].lA;
         cyc();
         chk_q($sformatf("v%0d", i), v[i].occ, v[i].outst);
         chk($sformatf("v%0d.full", i), 64'(full), 64'(v[i].full));
         chk($sformatf("v%0d.af", i), 64'(almostFull), 64'(v[i].af));
         chk($sformatf("v%0d.allocReady", i), 64'(allocReady), 64'(!v[i].full));
         chk($sformatf("v%0d.respReady", i), 64'(respReady), 64'(v[i].outst != 0));
         chk_hit($sformatf("v%0d", i), v[i].hv, v[i].hs, v[i].hd);
         chk($sformatf("v%0d.protoErr", i), 64'(protoErr), 64'd0);
      end
      idle_inputs();

      // PENDING on the youngest of three outstanding discards the older two
      do_reset();
      do_alloc(64'h40);
      do_alloc(64'h80);
      do_alloc(64'hC0);
      do_lookup(64'hC0);
      chk_hit("pend", 1'b1, 2'd1, 16'h0);
      chk_q("pend", 1, 3);
      do_beat(8'h11, 1'b0);
      do_beat(8'h12, 1'b1);
      chk_q("pend.b0", 1, 2);
      do_beat(8'h21, 1'b0);
      do_beat(8'h22, 1'b1);
      chk_q("pend.b1", 1, 1);
      do_lookup(64'h40);
      chk_hit("pend.discarded", 1'b1, 2'd0, 16'h0);
      do_beat(8'h31, 1'b0);
      do_beat(8'h32, 1'b1);
      chk_q("pend.b2", 1, 0);
      do_lookup(64'hC0);
      chk_hit("pend.hit", 1'b1, 2'd2, 16'h3231);
      chk("pend.empty", 64'(empty), 64'd1);

      // reset mid-burst drops the partial beat; then sticky protoErr
      do_reset();
      do_alloc(64'h40);
      do_beat(8'h11, 1'b0);
      do_reset();
      chk_q("midrst", 0, 0);
      chk("midrst.respReady", 64'(respReady), 64'd0);
      do_alloc(64'h40);
      do_beat(8'h33, 1'b0);
      do_beat(8'h44, 1'b1);
      chk("midrst.protoErr", 64'(protoErr), 64'd0);
      do_lookup(64'h40);
      chk_hit("midrst", 1'b1, 2'd2, 16'h4433);
      do_alloc(64'h80);
      do_beat(8'h55, 1'b1);
      chk("perr.set", 64'(protoErr), 64'd1);
      do_beat(8'h66, 1'b1);
      chk("perr.sticky0", 64'(protoErr), 64'd1);
      do_lookup(64'h80);
      chk_hit("perr.data", 1'b1, 2'd2, 16'h6655);
      do_alloc(64'hC0);
      do_beat(8'h77, 1'b0);
      do_beat(8'h88, 1'b1);
      chk("perr.sticky1", 64'(protoErr), 64'd1);
      do_reset();
      chk("perr.cleared", 64'(protoErr), 64'd0);

      // stale filled block: evicted and scrubbed only with the watchdog
      do_reset();
      do_alloc(64'h40);
      do_beat(8'h11, 1'b0);
      do_beat(8'h22, 1'b1);
      chk_q("wdog.filled", 1, 0);
      repeat (12) cyc();
`ifdef PREFETCH_WATCHDOG_EN
      chk_q("wdog.idle", 0, 0);
      do_lookup(64'h40);
      chk_hit("wdog", 1'b1, 2'd0, 16'h0);
`else
      chk_q("wdog.idle", 1, 0);
      do_lookup(64'h40);
      chk_hit("wdog", 1'b1, 2'd2, 16'h2211);
`endif
      chk_q("wdog.after", 0, 0);

      // flush with a simultaneous lookup keeps only the outstanding entry
      do_reset();
      do_alloc(64'h40);
      do_alloc(64'h80);
      do_alloc(64'hC0);
      do_beat(8'h11, 1'b0);
      do_beat(8'h22, 1'b1);
      do_beat(8'h33, 1'b0);
      do_beat(8'h44, 1'b1);
      chk_q("flush.pre", 3, 1);
      flush       = 1'b1;
      lookupValid = 1'b1;
      lookupAddr  = 64'h40;
      #1;
      chk("flush.lookupReady", 64'(lookupReady), 64'd0);
      cyc();
      flush       = 1'b0;
      lookupValid = 1'b0;
      chk_q("flush.post", 1, 1);
      chk_hit("flush.nolookup", 1'b0, 2'd0, 16'h0);
      do_lookup(64'h40);
      chk_hit("flush.freed", 1'b1, 2'd0, 16'h0);
      do_beat(8'h55, 1'b0);
      do_beat(8'h66, 1'b1);
      chk_q("flush.fill", 1, 0);
      do_lookup(64'hC0);
      chk_hit("flush.hit", 1'b1, 2'd2, 16'h6655);
      chk("flush.empty", 64'(empty), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
